// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_unit_pkg;
  localparam int          WORD_W       = 16;
  localparam logic [15:0] DEF_RESET_PC = 16'h3000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_MEM  = 3'd2,
    ST_IRLD = 3'd3,
    ST_HOLD = 3'd4
  } state_e;
endpackage

// File: rtl/fetch_unit_csa16.sv
// 16-bit carry-select adder: low byte ripples, high byte precomputes both carry-in cases.
module CSA16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Ci,
  output logic [15:0] S,
  output logic        Co
);
  logic [8:0] lo, hi0, hi1;

  assign lo  = {1'b0, A[7:0]} + {1'b0, B[7:0]} + {8'd0, Ci};
  assign hi0 = {1'b0, A[15:8]} + {1'b0, B[15:8]};
  assign hi1 = hi0 + 9'd1;

  assign S[7:0]        = lo[7:0];
  assign {Co, S[15:8]} = lo[8] ? hi1 : hi0;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns PC, drives MAR/MEM_RD, hands IR to decode
// with valid/ready, supports branch redirects and a sticky memory-timeout fault.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEF_RESET_PC,
  parameter int          TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic              LD_PC,
  input  logic [WORD_W-1:0] PC_TARGET,
  output logic [WORD_W-1:0] MAR,
  output logic              MEM_RD,
  input  logic              MEM_R,
  input  logic [WORD_W-1:0] MEM_DATA,
  output logic [WORD_W-1:0] PC,
  output logic [WORD_W-1:0] IR,
  output logic              IR_VALID,
  input  logic              IR_READY,
  output logic              FAULT
);
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d, mar_q, mar_d, mdr_q, mdr_d, ir_q, ir_d;
  logic              irv_q, irv_d, fault_q, fault_d, flush_q, flush_d;
  logic [15:0]       tmo_q, tmo_d;
  logic [WORD_W-1:0] pc_inc;
  logic              pc_co_unused;

  CSA16 u_pc_inc (
    .A  (pc_q),
    .B  (16'h0001),
    .Ci (1'b0),
    .S  (pc_inc),
    .Co (pc_co_unused)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    ir_d    = ir_q;
    irv_d   = irv_q;
    fault_d = fault_q;
    flush_d = flush_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: if (EN && !fault_q) state_d = ST_ADDR;
      ST_ADDR: begin
        mar_d   = pc_q;
        pc_d    = pc_inc;
        state_d = ST_MEM;
        if (LD_PC) flush_d = 1'b1;
      end
      ST_MEM: begin
        tmo_d = tmo_q + 16'd1;
        if (MEM_R) begin
          mdr_d = MEM_DATA;
          tmo_d = '0;
          // A redirect pending (or arriving now) makes this word stale: refetch.
          if (flush_q || LD_PC) begin
            flush_d = 1'b0;
            state_d = ST_ADDR;
          end else begin
            state_d = ST_IRLD;
          end
        end else if (TMO != 16'd0 && tmo_q + 16'd1 == TMO) begin
          fault_d = 1'b1;
          flush_d = 1'b0;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else if (LD_PC) begin
          flush_d = 1'b1;
        end
      end
      ST_IRLD: begin
        ir_d = mdr_q;
        if (LD_PC) begin
          state_d = ST_ADDR;
        end else begin
          irv_d   = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (LD_PC) begin
          irv_d   = 1'b0;
          state_d = ST_ADDR;
        end else if (IR_READY) begin
          irv_d   = 1'b0;
          state_d = EN ? ST_ADDR : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (LD_PC) pc_d = PC_TARGET;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      mar_q   <= '0;
      mdr_q   <= '0;
      ir_q    <= '0;
      irv_q   <= 1'b0;
      fault_q <= 1'b0;
      flush_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      ir_q    <= ir_d;
      irv_q   <= irv_d;
      fault_q <= fault_d;
      flush_q <= flush_d;
      tmo_q   <= tmo_d;
    end
  end

  assign MEM_RD   = (state_q == ST_MEM);
  assign MAR      = mar_q;
  assign PC       = pc_q;
  assign IR       = ir_q;
  assign IR_VALID = irv_q;
  assign FAULT    = fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table of single fetches plus stall,
// redirect, async-reset and timeout sequences against a simple memory model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, EN, LD_PC, MEM_R, IR_READY;
  logic [15:0] PC_TARGET, MAR, MEM_DATA, PC, IR;
  logic        MEM_RD, IR_VALID, FAULT;

  int n_chk = 0, n_fail = 0;
  logic mem_en;
  int   mem_lat, wait_cnt;

  fetch_unit #(.RESET_PC(16'h3000), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .EN(EN), .LD_PC(LD_PC), .PC_TARGET(PC_TARGET),
    .MAR(MAR), .MEM_RD(MEM_RD), .MEM_R(MEM_R), .MEM_DATA(MEM_DATA),
    .PC(PC), .IR(IR), .IR_VALID(IR_VALID), .IR_READY(IR_READY), .FAULT(FAULT)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a == 16'h3000) ? 16'h1234 : (a ^ 16'h5A5A);
  endfunction

  // Memory answers after mem_lat stalled MEM cycles.
  assign MEM_R    = mem_en && MEM_RD && (wait_cnt >= mem_lat);
  assign MEM_DATA = memf(MAR);
  always @(posedge clk or posedge rst)
    if (rst)                 wait_cnt <= 0;
    else if (MEM_RD && !MEM_R) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!IR_VALID && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("ir_valid_arrives", {31'd0, IR_VALID}, 32'd1);
  endtask

  task automatic accept();
    IR_READY = 1'b1;
    @(negedge clk);
    IR_READY = 1'b0;
    chk("ir_valid_after_accept", {31'd0, IR_VALID}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] start;
    int          lat;
    logic [15:0] ir;
    logic [15:0] pc;
    int          cyc;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int n, memc;
    logic rd_seen;
    vecs[0] = '{16'h3000, 0, 16'h1234, 16'h3001, 3};
    vecs[1] = '{16'h0010, 1, 16'h5A4A, 16'h0011, 4};
    vecs[2] = '{16'hFFFF, 0, 16'hA5A5, 16'h0000, 3};
    vecs[3] = '{16'h7FFF, 2, 16'h25A5, 16'h8000, 5};
    vecs[4] = '{16'h00FF, 3, 16'h5AA5, 16'h0100, 6};

    rst = 1'b1; EN = 0; LD_PC = 0; PC_TARGET = '0; IR_READY = 0;
    mem_en = 1'b1; mem_lat = 0;
    #12;
    chk("rst_pc", {16'd0, PC}, 32'h3000);
    chk("rst_mar", {16'd0, MAR}, 32'h0);
    chk("rst_ir", {16'd0, IR}, 32'h0);
    chk("rst_flags", {29'd0, MEM_RD, IR_VALID, FAULT}, 32'h0);
    @(negedge clk) rst = 1'b0;

    // Async reset in the middle of a memory wait.
    mem_en = 1'b0;
    EN = 1'b1;
    @(negedge clk) EN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midmem_rd", {31'd0, MEM_RD}, 32'd1);
    chk("midmem_mar", {16'd0, MAR}, 32'h3000);
    #2 rst = 1'b1;
    #1;
    chk("async_pc", {16'd0, PC}, 32'h3000);
    chk("async_mar", {16'd0, MAR}, 32'h0);
    chk("async_flags", {29'd0, MEM_RD, IR_VALID, FAULT}, 32'h0);
    @(negedge clk) rst = 1'b0;
    mem_en = 1'b1;

    // Stall in HOLD, then back-to-back fetch.
    EN = 1'b1;
    @(negedge clk);
    wait_valid(n);
    chk("hold_latency", n, 3);
    chk("hold_ir", {16'd0, IR}, 32'h1234);
    chk("hold_mar", {16'd0, MAR}, 32'h3000);
    chk("hold_pc", {16'd0, PC}, 32'h3001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, IR_VALID}, 32'd1);
      chk("stall_ir", {16'd0, IR}, 32'h1234);
    end
    IR_READY = 1'b1;
    @(negedge clk);
    IR_READY = 1'b0; EN = 1'b0;
    chk("release_valid", {31'd0, IR_VALID}, 32'd0);
    @(negedge clk);
    chk("next_mar", {16'd0, MAR}, 32'h3001);
    chk("next_pc", {16'd0, PC}, 32'h3002);
    wait_valid(n);
    chk("next_ir", {16'd0, IR}, 32'h6A5B);
    accept();

    // Vector table: single fetches from a redirected PC.
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      LD_PC = 1'b1; PC_TARGET = vecs[v].start; mem_lat = vecs[v].lat;
      @(negedge clk);
      LD_PC = 1'b0;
      chk("vec_pc_load", {16'd0, PC}, {16'd0, vecs[v].start});
      EN = 1'b1;
      @(negedge clk);
      EN = 1'b0;
      wait_valid(n);
      chk("vec_latency", n, vecs[v].cyc);
      chk("vec_mar", {16'd0, MAR}, {16'd0, vecs[v].start});
      chk("vec_ir", {16'd0, IR}, {16'd0, vecs[v].ir});
      chk("vec_pc", {16'd0, PC}, {16'd0, vecs[v].pc});
      accept();
    end

    // Redirect during the first MEM cycle: stale word dropped, refetch from target.
    mem_lat = 2;
    @(negedge clk) EN = 1'b1;
    @(negedge clk) EN = 1'b0;
    @(negedge clk);
    chk("redir_in_mem", {31'd0, MEM_RD}, 32'd1);
    chk("redir_old_mar", {16'd0, MAR}, 32'h0100);
    LD_PC = 1'b1; PC_TARGET = 16'h4000;
    @(negedge clk);
    LD_PC = 1'b0;
    chk("redir_pc", {16'd0, PC}, 32'h4000);
    wait_valid(n);
    chk("redir_ir", {16'd0, IR}, 32'h1A5A);
    chk("redir_mar", {16'd0, MAR}, 32'h4000);
    chk("redir_pc_after", {16'd0, PC}, 32'h4001);
    accept();

    // Memory never answers: fault after TIMEOUT MEM cycles, then no more fetches.
    mem_en = 1'b0;
    @(negedge clk) EN = 1'b1;
    @(negedge clk) EN = 1'b0;
    memc = 0; n = 0;
    while (!FAULT && n < 30) begin
      if (MEM_RD) memc++;
      @(negedge clk);
      n++;
    end
    chk("tmo_fault", {31'd0, FAULT}, 32'd1);
    chk("tmo_mem_cycles", memc, 4);
    chk("tmo_rd_low", {31'd0, MEM_RD}, 32'd0);
    EN = 1'b1;
    rd_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (MEM_RD) rd_seen = 1'b1;
    end
    chk("tmo_no_fetch", {31'd0, rd_seen}, 32'd0);
    chk("tmo_sticky", {31'd0, FAULT}, 32'd1);
    chk("tmo_mar_kept", {16'd0, MAR}, 32'h4001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch sequencer that owns the program-counter register and drives the MAR value consumed by the downstream PC address stage and by memory.
- Runs the fetch sequence MAR<-PC, PC<-PC+1; MDR<-M[MAR] (waits for memory ready); IR<-MDR.
- Hands the fetched instruction to decode with a valid/ready handshake.
- Accepts branch redirects (LD_PC) at any cycle and raises a fault flag if memory never answers.

Parameters:
- RESET_PC, 16'h3000, PC value loaded on reset.
- TIMEOUT, 255, maximum cycles spent in MEM waiting for MEM_R before FAULT is raised. 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- EN  input  1  fetch enable. While low, no new fetch starts.
- LD_PC  input  1  redirect strobe. Loads PC from PC_TARGET.
- PC_TARGET  input  16  redirect address.
- MAR  output  16  memory address register; feeds the PC address stage and memory.
- MEM_RD  output  1  memory read request.
- MEM_R  input  1  memory ready; MEM_DATA is valid in the same cycle.
- MEM_DATA  input  16  memory read data.
- PC  output  16  current program counter.
- IR  output  16  instruction register.
- IR_VALID  output  1  IR holds an instruction not yet consumed.
- IR_READY  input  1  decode accepts IR when IR_VALID and IR_READY are both high.
- FAULT  output  1  sticky memory-timeout flag.

Behaviour:
- Reset (async, rst=1):
  - PC=RESET_PC; MAR=0; IR=0; MDR=0.
  - MEM_RD=0; IR_VALID=0; FAULT=0.
  - State=IDLE; flush flag=0; timeout counter=0.
- States: IDLE, ADDR, MEM, IRLD, HOLD.
- IDLE:
  - If EN=1 and FAULT=0, go to ADDR.
  - Otherwise stay in IDLE.
- ADDR (1 cycle): MAR<=PC; PC<=PC+1, wrapping 16'hFFFF->16'h0000. Next state is MEM.
- MEM:
  - MEM_RD=1, driven combinationally from state.
  - Timeout counter increments each cycle.
  - On MEM_R=1: MDR<=MEM_DATA; counter cleared. If flush=1, clear flush and go to ADDR; otherwise go to IRLD.
  - If the counter reaches TIMEOUT with MEM_R=0 (and TIMEOUT≠0): FAULT<=1 and go to IDLE.
- IRLD (1 cycle): IR<=MDR; IR_VALID<=1; next state is HOLD.
- HOLD:
  - IR_VALID=1.
  - On IR_READY=1: IR_VALID<=0. Go to ADDR if EN=1, otherwise IDLE.
  - While IR_READY=0: IR and IR_VALID remain stable.
- Latency: with MEM_R high on the first MEM cycle, IR_VALID asserts 3 cycles after leaving IDLE (ADDR, MEM, IRLD). Back-to-back throughput is one instruction per 4 cycles with IR_READY tied high.
- LD_PC (any state): PC<=PC_TARGET, overriding the ADDR-state increment in the same cycle. Effect per state:
  - ADDR: MAR still takes the old PC, and flush<=1.
  - MEM: flush<=1; the returned word is discarded and a refetch starts from PC_TARGET.
  - IRLD: IR_VALID is not set, and the next state is ADDR.
  - HOLD: IR_VALID<=0 and the next state is ADDR; the IR_READY handshake in the same cycle is ignored.
  - IDLE: PC loads only.
- FAULT is cleared only by rst.
- A 16'hFFFF fetch returns PC=16'h0000.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=0, ADDR=1, MEM=2, IRLD=3, HOLD=4 (3 bits).
  - Default RESET_PC and the 16-bit word width.
- PC increment reuses the existing CSA16 (B=16'h0001, Ci=0). No other sub-module.

Test Plan:
- Reset mid-MEM with MEM_RD=1 -> all outputs return to reset values immediately (asynchronously); PC=16'h3000.
- EN=1; memory answers in 1 cycle with M[3000]=16'h1234 -> MAR=3000, IR=1234, IR_VALID high 3 cycles after leaving IDLE, PC=3001.
- IR_READY held low 5 cycles -> IR and IR_VALID stable; once IR_READY=1, the next fetch shows MAR=3001.
- LD_PC with PC_TARGET=16'h4000 in the first MEM cycle, MEM_R arriving 2 cycles later -> the old word is discarded, the next MAR=4000, and IR receives M[4000].
- TIMEOUT=4 with MEM_R never asserted -> FAULT=1 after 4 MEM cycles, state returns to IDLE, MEM_RD=0, and no further fetches occur.
- PC preloaded to 16'hFFFF via LD_PC -> MAR=FFFF, then PC=0000.
